// File: rtl/niosII_system_pkg.sv
// Shared types and constants for the sysid checker and its stall timer.
package niosII_system_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } sysid_state_e;

  localparam logic [31:0] SYSID_ID_OFFSET = 32'd0;
  localparam logic [31:0] SYSID_TS_OFFSET = 32'd4;

endpackage

// File: rtl/niosII_system_avm_read_timer.sv
// Counts waitrequest-stalled cycles of the current read; tc flags the stall limit.
module niosII_system_avm_read_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [15:0] LIM = 16'(LIMIT);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 16'd1;
  end

  assign tc = (cnt == LIM);

endmodule

// File: rtl/niosii_system_sysid_checker.sv
// Boot-time Avalon-MM reader of the sysid slave; compares ID and timestamp to expected values.
module niosii_system_sysid_checker
  import niosII_system_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR          = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1486253148,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  sysid_state_e state, state_nx;
  logic auto_pend, go, cap_id, cap_ts, abort, tmr_tc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    go       = 1'b0;
    cap_id   = 1'b0;
    cap_ts   = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE, DONE: if (start || auto_pend) begin
        go       = 1'b1;
        state_nx = RD_ID;
      end
      RD_ID: if (!avm_waitrequest) begin
        cap_id   = 1'b1;
        state_nx = RD_TS;
      end else if (tmr_tc) begin
        abort    = 1'b1;
        state_nx = DONE;
      end
      RD_TS: if (!avm_waitrequest) begin
        cap_ts   = 1'b1;
        state_nx = DONE;
      end else if (tmr_tc) begin
        abort    = 1'b1;
        state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Auto-start is a one-shot: armed by reset, consumed on the first clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) auto_pend <= AUTO_START;
    else          auto_pend <= 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else if (go) begin
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      if (cap_id) begin
        id_value <= avm_readdata;
        id_ok    <= (avm_readdata == EXPECTED_ID);
      end
      if (cap_ts) begin
        ts_value <= avm_readdata;
        ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
      end
      if (abort) timeout <= 1'b1;
    end
  end

  // Each read gets its own stall budget, so the timer restarts between the two words.
  niosII_system_avm_read_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk   (clock),
    .rst_n (reset_n),
    .clr   (go | cap_id),
    .en    (avm_read & avm_waitrequest),
    .tc    (tmr_tc)
  );

  assign busy        = (state == RD_ID) || (state == RD_TS);
  assign avm_read    = busy;
  assign done        = (state == DONE);
  assign pass        = done && id_ok && ts_ok && !timeout;
  assign avm_address = BASE_ADDR + ((state == RD_TS) ? SYSID_TS_OFFSET : SYSID_ID_OFFSET);

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Directed + randomized checks of the sysid checker against a transaction-level model.
module tb_niosii_system_sysid_checker;

  localparam logic [31:0] BASE   = 32'h0001_0040;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1486253148;
  localparam int          T      = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] avm_address, avm_readdata, id_value, ts_value;
  logic        avm_read, avm_waitrequest;
  logic        busy, done, pass, id_ok, ts_ok, timeout;

  int          tests = 0;
  int          fails = 0;

  logic [31:0] word0 = EXP_ID;
  logic [31:0] word1 = EXP_TS;
  int          wait_id = 0;
  int          wait_ts = 0;
  int          wcnt = 0;
  int          read_cycles = 0;
  int          reads_done = 0;
  int          addr_bad = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  niosii_system_sysid_checker #(
    .BASE_ADDR(BASE), .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
    .TIMEOUT_CYCLES(T), .AUTO_START(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .busy(busy), .done(done), .pass(pass),
    .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout),
    .id_value(id_value), .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  // Slave: stalls each read for a per-word number of cycles, then returns its word.
  assign avm_waitrequest = avm_read && (wcnt < ((avm_address == BASE) ? wait_id : wait_ts));
  assign avm_readdata    = (avm_address == BASE) ? word0 :
                           (avm_address == BASE + 32'd4) ? word1 : 32'hDEAD_BEEF;

  always @(posedge clock) wcnt <= (avm_read && avm_waitrequest) ? wcnt + 1 : 0;

  always @(negedge clock) begin
    if (avm_read) read_cycles++;
    if (avm_read && !avm_waitrequest) reads_done++;
    if (avm_read && avm_waitrequest && prev_stall && avm_address !== prev_addr) addr_bad++;
    prev_stall = avm_read && avm_waitrequest;
    prev_addr  = avm_address;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One check: optional start pulse, optional stray start at edge start_at, model comparison.
  task automatic run(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                     input int wid, input int wts, input bit use_start, input int start_at);
    int k, rc0, rd0, ab0, exp_k, exp_reads;
    logic [31:0] e_idv, e_tsv;
    bit e_idok, e_tsok, e_to;
    word0 = w0; word1 = w1; wait_id = wid; wait_ts = wts;
    if (use_start) begin
      @(negedge clock);
      start = 1'b1;
    end
    rc0 = read_cycles; rd0 = reads_done; ab0 = addr_bad;
    @(posedge clock); #1;
    start = 1'b0;
    chk({tag, ".busy_at_start"}, busy, 1);
    chk({tag, ".done_cleared"}, done, 0);
    chk({tag, ".id_ok_cleared"}, id_ok, 0);
    k = 0;
    while (k < 200) begin
      @(posedge clock); #1;
      k++;
      if (done) break;
      start = (k == start_at);
    end
    start = 1'b0;

    if (wid > T) begin
      exp_k = T + 1; e_to = 1; exp_reads = 0;
      e_idv = 0; e_tsv = 0; e_idok = 0; e_tsok = 0;
    end else if (wts > T) begin
      exp_k = wid + 1 + T + 1; e_to = 1; exp_reads = 1;
      e_idv = w0; e_idok = (w0 == EXP_ID); e_tsv = 0; e_tsok = 0;
    end else begin
      exp_k = wid + wts + 2; e_to = 0; exp_reads = 2;
      e_idv = w0; e_idok = (w0 == EXP_ID); e_tsv = w1; e_tsok = (w1 == EXP_TS);
    end

    chk({tag, ".edges_to_done"}, k, exp_k);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".avm_read"}, avm_read, 0);
    chk({tag, ".pass"}, pass, e_idok && e_tsok && !e_to);
    chk({tag, ".id_ok"}, id_ok, e_idok);
    chk({tag, ".ts_ok"}, ts_ok, e_tsok);
    chk({tag, ".timeout"}, timeout, e_to);
    chk({tag, ".id_value"}, id_value, e_idv);
    chk({tag, ".ts_value"}, ts_value, e_tsv);
    chk({tag, ".read_cycles"}, read_cycles - rc0, exp_k);
    chk({tag, ".reads_done"}, reads_done - rd0, exp_reads);
    chk({tag, ".addr_stable"}, addr_bad - ab0, 0);
    if (start_at > 0) begin
      repeat (3) @(posedge clock);
      #1;
      chk({tag, ".no_queued_start"}, {busy, done}, 2'b01);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst.avm_read", avm_read, 0);
    chk("rst.avm_address", avm_address, BASE);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.pass", pass, 0);
    chk("rst.flags", {id_ok, ts_ok, timeout}, 0);
    chk("rst.id_value", id_value, 0);
    chk("rst.ts_value", ts_value, 0);

    // Auto-start after release
    @(negedge clock);
    reset_n = 1'b1;
    run("auto", EXP_ID, EXP_TS, 0, 0, 1'b0, -1);

    run("ts_mismatch", EXP_ID, EXP_TS + 32'd1, 0, 0, 1'b1, -1);
    run("id_mismatch", 32'h1234_5678, EXP_TS, 0, 0, 1'b1, -1);
    run("stall5", EXP_ID, EXP_TS, 5, 5, 1'b1, -1);
    run("stuck", EXP_ID, EXP_TS, 1000, 1000, 1'b1, -1);
    run("stall_at_limit", EXP_ID, EXP_TS, T, T, 1'b1, -1);
    run("stall_over_limit", EXP_ID, EXP_TS, T + 1, 0, 1'b1, -1);
    run("ts_timeout", EXP_ID, EXP_TS, 2, T + 1, 1'b1, -1);
    run("start_in_rd_ts", EXP_ID, EXP_TS, 0, 3, 1'b1, 1);
    run("start_in_rd_id", EXP_ID, EXP_TS, 4, 0, 1'b1, 2);

    for (int i = 0; i < 12; i++) begin
      logic [31:0] w0, w1;
      w0 = $urandom_range(0, 1) ? EXP_ID : $urandom;
      w1 = $urandom_range(0, 1) ? EXP_TS : $urandom;
      run($sformatf("rand%0d", i), w0, w1, $urandom_range(0, 10), $urandom_range(0, 10), 1'b1, -1);
    end

    // Reset while the ID read is stalled
    wait_id = 1000;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midrst.avm_read", avm_read, 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.done_pass", {done, pass}, 0);
    chk("midrst.flags", {id_ok, ts_ok, timeout}, 0);
    chk("midrst.avm_address", avm_address, BASE);
    wait_id = 0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    run("rerun", EXP_ID, EXP_TS, 0, 0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
